// File: rtl/scroll_sequencer.sv
// scroll_sequencer: step pacing, pause/single-step/restart control and HEX/LEDR display registers
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   i_run_key             pause/resume toggle request (async level)
//   i_step_key            single-step request, honoured only while paused (async level)
//   i_restart_key         restart request (async level)
//   i_speed               rate select, step period = BASE_DIV >> i_speed
//   i_ledr_en, i_hex_en   commit enables sampled on each step
//   i_next_hex0..5        next segment patterns (active-low)
//   o_step                one-cycle advance strobe
//   o_sm_reset            reset to the scrolling state machine
//   o_hex0..5, o_ledr     display registers
//   o_paused              registered pause indicator
module scroll_sequencer #(
  parameter int BASE_DIV = 25_000_000,
  parameter int DIV_W    = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run_key,
  input  logic       i_step_key,
  input  logic       i_restart_key,
  input  logic [1:0] i_speed,
  input  logic       i_ledr_en,
  input  logic       i_hex_en,
  input  logic [6:0] i_next_hex0,
  input  logic [6:0] i_next_hex1,
  input  logic [6:0] i_next_hex2,
  input  logic [6:0] i_next_hex3,
  input  logic [6:0] i_next_hex4,
  input  logic [6:0] i_next_hex5,
  output logic       o_step,
  output logic       o_sm_reset,
  output logic [6:0] o_hex0,
  output logic [6:0] o_hex1,
  output logic [6:0] o_hex2,
  output logic [6:0] o_hex3,
  output logic [6:0] o_hex4,
  output logic [6:0] o_hex5,
  output logic [9:0] o_ledr,
  output logic       o_paused
);

  typedef enum logic [1:0] {S_RUN, S_PAUSE, S_RESTART} state_t;

  localparam logic [DIV_W:0]   BASE     = (DIV_W + 1)'(BASE_DIV);
  localparam logic [DIV_W-1:0] CNT_INIT = DIV_W'(BASE_DIV - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_next;
  logic [DIV_W-1:0] w_reload;
  logic [DIV_W:0]   w_div;
  logic             r_step;
  logic             w_step_next;
  logic             r_paused;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_key_d;
  logic [2:0]       r_pulse;
  logic             w_run_p;
  logic             w_step_p;
  logic             w_rst_p;
  logic [5:0][6:0]  r_hex;
  logic [5:0][6:0]  w_next_hex;
  logic [9:0]       r_ledr;

  // Key bits: 0 = run, 1 = step, 2 = restart. Pulse is registered, giving 3 cycles from key edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_key_d <= '0;
      r_pulse <= '0;
    end else begin
      r_sync1 <= {i_restart_key, i_step_key, i_run_key};
      r_sync2 <= r_sync1;
      r_key_d <= r_sync2;
      r_pulse <= r_sync2 & ~r_key_d;
    end
  end

  assign w_run_p  = r_pulse[0];
  assign w_step_p = r_pulse[1];
  assign w_rst_p  = r_pulse[2];

  // Truncating after the subtract keeps BASE_DIV == 2**DIV_W correct (reload becomes all ones).
  assign w_div    = BASE >> i_speed;
  assign w_reload = DIV_W'(w_div - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_RUN;
      r_cnt    <= CNT_INIT;
      r_step   <= 1'b0;
      r_paused <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_step   <= w_step_next;
      r_paused <= (r_state == S_PAUSE);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_step_next  = 1'b0;
    case (r_state)
      S_RUN: begin
        w_step_next  = (r_cnt == '0);
        w_cnt_next   = (r_cnt == '0) ? w_reload : r_cnt - 1'b1;
        w_state_next = w_run_p ? S_PAUSE : S_RUN;
      end
      S_PAUSE: begin
        w_state_next = w_run_p ? S_RUN : S_PAUSE;
        w_step_next  = w_step_p & ~w_run_p;
      end
      default: begin
        w_state_next = S_RUN;
        w_cnt_next   = w_reload;
      end
    endcase
    if (w_rst_p) begin
      w_state_next = S_RESTART;
      w_step_next  = 1'b1;
    end
  end

  assign w_next_hex = {i_next_hex5, i_next_hex4, i_next_hex3, i_next_hex2, i_next_hex1, i_next_hex0};

  // The restart cycle also raises step; clearing takes precedence over the commit there.
  always_ff @(posedge clk) begin
    if (reset || r_state == S_RESTART) begin
      r_hex  <= {6{7'h7F}};
      r_ledr <= '0;
    end else if (r_step) begin
      if (i_hex_en) r_hex <= w_next_hex;
      if (i_ledr_en) r_ledr <= (&r_ledr) ? '0 : {r_ledr[8:0], 1'b1};
    end
  end

  assign o_step     = r_step;
  assign o_sm_reset = reset | (r_state == S_RESTART);
  assign o_paused   = r_paused;
  assign o_ledr     = r_ledr;
  assign o_hex0     = r_hex[0];
  assign o_hex1     = r_hex[1];
  assign o_hex2     = r_hex[2];
  assign o_hex3     = r_hex[3];
  assign o_hex4     = r_hex[4];
  assign o_hex5     = r_hex[5];

endmodule

// File: doc/scroll_sequencer.md
# scroll_sequencer

Pacing and display-register controller for the DE1-SoC scrolling display. Generates the one-cycle `step` strobe that advances the scrolling-display state machine at a user-selected rate, and owns the HEX0–HEX5 shift registers and the LEDR loop counter. It commits `next_hex*` and the LEDR pattern on each enabled step, and handles pause, single-step and restart requests from debounced KEY inputs.

## Interface
- BASE_DIV, 25_000_000 — step period in clk cycles at speed 0 (0.5 s at 50 MHz); must be a power of two ≥ 8 in simulation builds.
- DIV_W, 25 — prescaler counter width; must satisfy 2^DIV_W ≥ BASE_DIV.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- run_key  in  1  pause/resume toggle request, level, asynchronous to clk.
- step_key  in  1  single-step request, level, asynchronous; honoured only while paused.
- restart_key  in  1  restart request, level, asynchronous.
- speed  in  2  rate select; step period = BASE_DIV >> speed.
- ledr_en  in  1  from state machine: advance LEDR on this step.
- hex_en  in  1  from state machine: commit next_hex* on this step.
- next_hex0..next_hex5  in  7 each  next segment patterns, active-low.
- step  out  1  one-cycle advance strobe to the state machine.
- sm_reset  out  1  synchronous reset to the state machine.
- hex0..hex5  out  7 each  current segment registers, fed back as current_hex*.
- ledr  out  10  LED loop pattern, fed back as current_ledr.
- paused  out  1  high in PAUSE.

## Operation
- Each of run_key, step_key and restart_key passes through a 2-flop synchronizer and then a rising-edge detector. This yields the `run_p`, `step_p` and `rst_p` pulses, each one cycle wide.
- FSM states are RUN, PAUSE and RESTART. Reset enters RUN.
- RUN:
  - Prescaler `cnt` counts down and `step` fires on the cycle `cnt == 0`; `cnt` then reloads with (BASE_DIV >> speed) − 1.
  - `run_p` goes to PAUSE.
- PAUSE:
  - `cnt` holds its value.
  - `step_p` produces `step` on the next cycle; `cnt` is unchanged.
  - `run_p` goes to RUN, and counting resumes from the held `cnt`.
- RESTART is entered from any state on `rst_p`. It lasts exactly 1 cycle:
  - `sm_reset` = 1 and `step` = 1.
  - Next cycle: hex0..5 = 7'h7F, `ledr` = 0, `cnt` = reload value.
  - Exits to RUN.
- Commit on `step`:
  - If `hex_en`, hex0..5 <= next_hex0..5.
  - If `ledr_en`, `ledr` advances as a thermometer: `ledr <= {ledr[8:0],1'b1}`. When `ledr` == 10'h3FF, it instead wraps to 10'h000.
  - With no enable, the registers hold.
- Priority when pulses coincide:
  - `rst_p` wins over everything.
  - `run_p` and `step_p` together in PAUSE: resume only, no extra step.
  - `run_p` on a RUN cycle where `cnt == 0`: the step still fires, then the FSM enters PAUSE.
- `speed` changes take effect at the next reload only; the in-flight count is not altered.
- `sm_reset` = reset OR (state == RESTART).

## Timing
- Reset values:
  - step = 0, sm_reset = 1 during reset.
  - hex0..5 = 7'h7F, ledr = 10'h000, paused = 0.
  - state = RUN, cnt = BASE_DIV − 1.
- First `step` after reset deasserts: BASE_DIV cycles later at speed 0.
- Step period in RUN is exactly BASE_DIV >> speed cycles. At speed 3 with BASE_DIV = 8, `step` is high every cycle.
- Latency:
  - KEY edge to `*_p`: 3 cycles.
  - `step_p` to `step`: 1 cycle.
  - `step` to hex/ledr update: 1 cycle (registered on the `step` edge).
- `paused` follows state with 1 cycle registered latency; it is 0 in RESTART.
- Reset mid-step overrides the commit: the registers take their reset values.
- The held key level never retriggers a pulse; a new rising edge is required.

## Test plan
- Reset, BASE_DIV = 8, speed = 0:
  - All outputs match the reset values.
  - `step` pulses at cycles 8, 16 and 24 after reset release.
  - Speed 2 gives a period of 2 after the next reload.
- Step with hex_en = 1, next_hex0..5 = 7'h46, 7'h0C, 7'h06, 7'h48, 7'h7F, 7'h79 -> hex0..5 equal those values one cycle after `step`. With hex_en = 0, hex0..5 are unchanged.
- Eleven steps with ledr_en = 1 -> `ledr` walks 001, 003, …, 3FF, then 000.
- Pause/step sequence:
  - Pulse run_key -> paused = 1 and no `step` for 50 cycles.
  - Each step_key edge yields exactly one `step` 4 cycles after the edge.
  - Holding step_key high for 20 cycles yields one `step` only.
  - run_key again -> RUN resumes and the remaining count is preserved.
- restart_key pulsed during PAUSE, with hex = nonzero and ledr = 3FF:
  - One cycle with sm_reset = 1 and step = 1.
  - Then hex0..5 = 7F, ledr = 0, paused = 0, and the first RUN step arrives 8 cycles later.
- Coincident events:
  - run_p on the `cnt == 0` cycle -> the step fires, then the FSM pauses.
  - rst_p together with run_p -> RESTART, then RUN.
  - Reset asserted on a `step` cycle -> reset values win.
